// File: rtl/spidergon_pkg.sv
// Shared Spidergon definitions: flit type codes, routing directions, FSM state
// encoding and the head-flit packer used by both the transmitter and receiver.
package spidergon_pkg;

    // Flit type codes, carried in the two MSBs of every flit
    localparam logic [1:0] HEAD_FLIT = 2'b01;
    localparam logic [1:0] BODY_FLIT = 2'b10;
    localparam logic [1:0] TAIL_FLIT = 2'b00;
    localparam logic [1:0] HEADER    = 2'b11;
    localparam logic [1:0] HEAD_TAIL = 2'b11;

    // Routing directions chosen by the node
    localparam logic [1:0] STOP           = 2'd0;
    localparam logic [1:0] ACROSS         = 2'd1;
    localparam logic [1:0] CLOCKWISE      = 2'd2;
    localparam logic [1:0] ANTI_CLOCKWISE = 2'd3;

    // Widest flit the packer can build; callers truncate to their own width
    localparam int unsigned MAX_FLIT_W = 64;

    typedef enum logic [1:0] {
        StIdle,
        StHead,
        StData
    } tx_state_e;

    // Builds {ftype, vc, dest, zeros} right-aligned in a MAX_FLIT_W word
    function automatic logic [MAX_FLIT_W-1:0] pack_head(
        input logic [1:0]  ftype,
        input int unsigned vc,
        input int unsigned dest,
        input int unsigned data_w,
        input int unsigned vc_w,
        input int unsigned dest_w
    );
        logic [MAX_FLIT_W-1:0] f;
        f = MAX_FLIT_W'(ftype) << data_w;
        f = f | (MAX_FLIT_W'(vc) << (data_w - vc_w));
        f = f | (MAX_FLIT_W'(dest) << (data_w - vc_w - dest_w));
        return f;
    endfunction

endpackage

// File: rtl/spidergon_ni_tx.sv
// Network-interface transmitter: turns a message descriptor plus a payload stream
// into a wormhole packet of typed flits for the local injection port of a node.
module spidergon_ni_tx
    import spidergon_pkg::*;
#(
    parameter int unsigned NUM_OF_NODES            = 8,
    parameter int unsigned FLIT_DATA_WIDTH         = 16,
    parameter int unsigned NUM_OF_VIRTUAL_CHANNELS = 2,
    parameter int unsigned NODE_IDENTIFIER         = 0,
    parameter int unsigned MAX_PAYLOAD_FLITS       = 4,
    localparam int unsigned DEST_W           = $clog2(NUM_OF_NODES),
    localparam int unsigned VC_W             = $clog2(NUM_OF_VIRTUAL_CHANNELS),
    localparam int unsigned LEN_W            = $clog2(MAX_PAYLOAD_FLITS + 1),
    localparam int unsigned FLIT_TOTAL_WIDTH = 2 + FLIT_DATA_WIDTH
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               msg_valid,
    output logic                               msg_ready,
    input  logic [DEST_W-1:0]                  msg_dest,
    input  logic [VC_W-1:0]                    msg_vc,
    input  logic [LEN_W-1:0]                   msg_len,
    input  logic                               pay_valid,
    output logic                               pay_ready,
    input  logic [FLIT_DATA_WIDTH-1:0]         pay_data,
    output logic [FLIT_TOTAL_WIDTH-1:0]        flit_out,
    output logic                               flit_out_valid,
    output logic [VC_W-1:0]                    flit_out_vc,
    input  logic [NUM_OF_VIRTUAL_CHANNELS-1:0] node_vc_is_ready,
    input  logic [NUM_OF_VIRTUAL_CHANNELS-1:0] node_vc_is_full,
    output logic                               busy,
    output logic                               pkt_sent
);

    tx_state_e             state_q, state_d;
    logic [DEST_W-1:0]     dest_q, dest_d;
    logic [VC_W-1:0]       vc_q, vc_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic [LEN_W-1:0]      len_clamped;
    logic                  vc_go;
    logic                  emit;
    logic                  emit_last;
    logic [FLIT_TOTAL_WIDTH-1:0] emit_flit;

    // The node id only matters to receive-side bookkeeping
    logic unused_node_id;
    assign unused_node_id = (NODE_IDENTIFIER == 0);

    // Oversized lengths are clamped rather than rejected
    assign len_clamped = (msg_len > LEN_W'(MAX_PAYLOAD_FLITS)) ? LEN_W'(MAX_PAYLOAD_FLITS)
                                                              : msg_len;

    // Only the packet's own VC gates injection
    assign vc_go     = node_vc_is_ready[vc_q] & ~node_vc_is_full[vc_q];
    assign msg_ready = (state_q == StIdle) & ~reset;
    assign pay_ready = (state_q == StData) & ~node_vc_is_full[vc_q] & ~reset;
    assign busy      = (state_q != StIdle) | flit_out_valid;

    // Next-state, descriptor latch and emit decision
    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        vc_d      = vc_q;
        rem_d     = rem_q;
        emit      = 1'b0;
        emit_last = 1'b0;
        emit_flit = '0;
        unique case (state_q)
            StIdle: begin
                if (msg_valid) begin
                    dest_d  = msg_dest;
                    vc_d    = msg_vc;
                    rem_d   = len_clamped;
                    state_d = StHead;
                end
            end
            StHead: begin
                if (vc_go) begin
                    emit = 1'b1;
                    if (rem_q == '0) begin
                        emit_flit = FLIT_TOTAL_WIDTH'(pack_head(HEADER, 32'(vc_q), 32'(dest_q),
                                        FLIT_DATA_WIDTH, VC_W, DEST_W));
                        emit_last = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        emit_flit = FLIT_TOTAL_WIDTH'(pack_head(HEAD_FLIT, 32'(vc_q), 32'(dest_q),
                                        FLIT_DATA_WIDTH, VC_W, DEST_W));
                        state_d   = StData;
                    end
                end
            end
            StData: begin
                if (pay_valid && pay_ready) begin
                    emit  = 1'b1;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        emit_flit = {TAIL_FLIT, pay_data};
                        emit_last = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        emit_flit = {BODY_FLIT, pay_data};
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and descriptor registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            dest_q  <= '0;
            vc_q    <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            vc_q    <= vc_d;
            rem_q   <= rem_d;
        end
    end

    // Output flit register; valid for exactly one cycle per emit decision
    always_ff @(posedge clk) begin
        if (reset) begin
            flit_out       <= '0;
            flit_out_valid <= 1'b0;
            flit_out_vc    <= '0;
            pkt_sent       <= 1'b0;
        end else begin
            flit_out_valid <= emit;
            pkt_sent       <= emit & emit_last;
            if (emit) begin
                flit_out    <= emit_flit;
                flit_out_vc <= vc_q;
            end
        end
    end

endmodule

// File: tb/tb_spidergon_ni_tx.sv
// Self-checking bench for spidergon_ni_tx: directed packets, expected flits queued
// at descriptor time and compared (content, VC, pkt_sent, cycle) as they appear.
module tb_spidergon_ni_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        msg_valid;
    logic        msg_ready;
    logic [2:0]  msg_dest;
    logic        msg_vc;
    logic [2:0]  msg_len;
    logic        pay_valid;
    logic        pay_ready;
    logic [15:0] pay_data;
    logic [17:0] flit_out;
    logic        flit_out_valid;
    logic        flit_out_vc;
    logic [1:0]  node_vc_is_ready;
    logic [1:0]  node_vc_is_full;
    logic        busy;
    logic        pkt_sent;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic [17:0] flit;
        logic        vc;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    spidergon_ni_tx #(
        .NUM_OF_NODES(8),
        .FLIT_DATA_WIDTH(16),
        .NUM_OF_VIRTUAL_CHANNELS(2),
        .NODE_IDENTIFIER(0),
        .MAX_PAYLOAD_FLITS(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .msg_valid(msg_valid),
        .msg_ready(msg_ready),
        .msg_dest(msg_dest),
        .msg_vc(msg_vc),
        .msg_len(msg_len),
        .pay_valid(pay_valid),
        .pay_ready(pay_ready),
        .pay_data(pay_data),
        .flit_out(flit_out),
        .flit_out_valid(flit_out_valid),
        .flit_out_vc(flit_out_vc),
        .node_vc_is_ready(node_vc_is_ready),
        .node_vc_is_full(node_vc_is_full),
        .busy(busy),
        .pkt_sent(pkt_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every valid flit must match the oldest expected entry
    always @(negedge clk) begin
        exp_t e;
        if (flit_out_valid === 1'b1) begin
            vectors++;
            assert (sb.size() > 0) else begin
                miscompares++;
                $error("FAIL sb_extra: got flit %h, want none", flit_out);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("flit", 32'(flit_out), 32'(e.flit));
                check("flit_vc", 32'(flit_out_vc), 32'(e.vc));
                check("pkt_sent", 32'(pkt_sent), 32'(e.last));
                check("flit_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else begin
            check("pkt_sent_idle", 32'(pkt_sent), 32'(0));
        end
    end

    // One packet: accept descriptor, queue the model's flits, then drive cycle k=1..19
    // with per-cycle full/ready shaping and an optional mid-packet reset.
    task automatic run_pkt(
        input logic [2:0]  dest,
        input logic        vc,
        input logic [2:0]  len,
        input logic [63:0] d,
        input logic [19:0] full0_mask,
        input bit          tog1,
        input int          rdy1_k,
        input int          hd,
        input int          si,
        input int          sd,
        input int          reset_k,
        input int          rdy_k
    );
        int nl;
        int t;
        int idx;
        int c;
        exp_t e;
        nl = (len > 3'd4) ? 4 : int'(len);
        msg_valid        = 1'b1;
        msg_dest         = dest;
        msg_vc           = vc;
        msg_len          = len;
        node_vc_is_full  = 2'b00;
        node_vc_is_ready = {(rdy1_k == 0), 1'b1};
        @(negedge clk);
        check("accept_rdy", 32'(msg_ready), 32'(1));
        t = cyc;
        e.flit = {(nl == 0) ? 2'b11 : 2'b01, vc, dest, 12'h000};
        e.vc   = vc;
        e.last = (nl == 0);
        e.cyc  = t + 2 + hd;
        if (reset_k == 0 || e.cyc <= t + reset_k) sb.push_back(e);
        for (int i = 1; i <= nl; i++) begin
            c = t + 2 + hd + i + ((si != 0 && i >= si) ? sd : 0);
            e.flit = {(i == nl) ? 2'b00 : 2'b10, d[16*(i-1) +: 16]};
            e.last = (i == nl);
            e.cyc  = c;
            if (reset_k == 0 || c <= t + reset_k) sb.push_back(e);
        end
        idx = 0;
        for (int k = 1; k < 20; k++) begin
            @(posedge clk);
            #1;
            msg_valid = 1'b0;
            if (reset_k != 0 && k == reset_k) reset = 1'b1;
            if (reset_k != 0 && k == reset_k + 1) reset = 1'b0;
            node_vc_is_full  = {tog1 ? k[0] : 1'b0, full0_mask[k]};
            node_vc_is_ready = {(k >= rdy1_k), 1'b1};
            pay_valid = (idx < nl) && !(reset_k != 0 && k > reset_k);
            pay_data  = (idx < 4) ? d[16*idx +: 16] : 16'h0;
            @(negedge clk);
            if (pay_valid && pay_ready) idx++;
            if (full0_mask[k]) check("stall_pay_ready", 32'(pay_ready), 32'(0));
            if (full0_mask[k-1]) check("stall_no_flit", 32'(flit_out_valid), 32'(0));
            if (k >= 2 && k <= rdy1_k) check("head_held", 32'(flit_out_valid), 32'(0));
            if (k == rdy_k) check("ready_again", 32'(msg_ready), 32'(1));
            if (reset_k != 0 && k == reset_k + 1) begin
                check("rst_valid", 32'(flit_out_valid), 32'(0));
                check("rst_busy", 32'(busy), 32'(0));
                break;
            end
        end
        @(posedge clk);
        #1;
        pay_valid        = 1'b0;
        node_vc_is_full  = 2'b00;
        node_vc_is_ready = 2'b11;
        if (reset_k == 0) begin
            check("pay_consumed", 32'(idx), 32'(nl));
            check("done_busy", 32'(busy), 32'(0));
        end
        check("sb_drained", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        reset            = 1'b1;
        msg_valid        = 1'b1;
        msg_dest         = 3'd7;
        msg_vc           = 1'b1;
        msg_len          = 3'd2;
        pay_valid        = 1'b0;
        pay_data         = 16'h0;
        node_vc_is_ready = 2'b11;
        node_vc_is_full  = 2'b00;

        // Reset held three cycles with a descriptor pending
        repeat (3) begin
            @(negedge clk);
            check("rst_msg_ready", 32'(msg_ready), 32'(0));
            check("rst_flit_valid", 32'(flit_out_valid), 32'(0));
            check("rst_flit", 32'(flit_out), 32'(0));
            check("rst_flit_vc", 32'(flit_out_vc), 32'(0));
            check("rst_busy", 32'(busy), 32'(0));
            check("rst_pkt_sent", 32'(pkt_sent), 32'(0));
            check("rst_pay_ready", 32'(pay_ready), 32'(0));
        end
        @(posedge clk);
        #1;
        reset     = 1'b0;
        msg_valid = 1'b0;
        @(negedge clk);
        check("post_rst_msg_ready", 32'(msg_ready), 32'(1));
        @(posedge clk);
        #1;

        // Header-only packet
        run_pkt(3'd5, 1'b1, 3'd0, 64'h0, 20'h0, 1'b0, 0, 0, 0, 0, 0, 2);
        // Three-word packet, back-to-back payload
        run_pkt(3'd3, 1'b0, 3'd3, 64'h0000_3333_2222_1111, 20'h0, 1'b0, 0, 0, 0, 0, 0, 5);
        // Same packet, VC0 full for three cycles after the first body flit, VC1 toggling
        run_pkt(3'd3, 1'b0, 3'd3, 64'h0000_3333_2222_1111, 20'h00038, 1'b1, 0, 0, 2, 3, 0, 0);
        // Head withheld until VC1 becomes ready
        run_pkt(3'd6, 1'b1, 3'd1, 64'h0000_0000_0000_abcd, 20'h0, 1'b0, 5, 4, 0, 0, 0, 0);
        // Oversized length clamps to four payload words; self-addressed
        run_pkt(3'd0, 1'b1, 3'd7, 64'hdddd_cccc_bbbb_aaaa, 20'h0, 1'b0, 0, 0, 0, 0, 0, 6);
        // Reset after the second flit of a four-word packet
        run_pkt(3'd4, 1'b0, 3'd4, 64'h4444_3333_2222_1111, 20'h0, 1'b0, 0, 0, 0, 0, 4, 0);
        // Recovery packet
        run_pkt(3'd2, 1'b0, 3'd1, 64'h0000_0000_0000_5a5a, 20'h0, 1'b0, 0, 0, 0, 0, 0, 3);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
